branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  Sequences ID-stage branch/jump resolution for the 5-stage MIPS pipeline.
//  - Detects when a branch/jr operand is not yet available at ID. Holds PC/IF-ID and injects ID/EX bubbles until the operand can be forwarded.
//  - Then issues the PC redirect and the IF/ID flush for taken control transfers.
//  - Sits beside the ID-stage branch comparator and consumes its Branch/Output pair.
// PARAMETERS
//  DELAY_SLOT  0   1: taken transfer does not flush IF/ID (MIPS delay slot); 0: flush
//  CNT_W       32  width of each statistics counter (BRANCH_STATS_EN only)
// PORTS
//  Clk          in   1      pipeline clock, rising edge
//  Rst          in   1      asynchronous reset, active-low
//  Branch       in   1      ID instr is bne/j/jal/jr (from branch comparator)
//  Taken        in   1      comparator outcome: transfer taken
//  IdRs         in   5      ID rs field
//  IdRt         in   5      ID rt field
//  RsUsed       in   1      ID control reads rs (bne, jr)
//  RtUsed       in   1      ID control reads rt (bne)
//  ExRegWrite   in   1      EX-stage instr writes a register
//  ExMemRead    in   1      EX-stage instr is a load
//  ExDst        in   5      EX-stage destination register
//  MemMemRead   in   1      MEM-stage instr is a load
//  MemDst       in   5      MEM-stage destination register
//  ExtStall     in   1      external freeze (memory wait); pipeline holds
//  PCWrite      out  1      PC update enable
//  IFIDWrite    out  1      IF/ID register enable
//  IDEXBubble   out  1      zero ID/EX control fields this cycle
//  IFIDFlush    out  1      clear IF/ID this cycle
//  Redirect     out  1      select branch/jump target as next PC
//  StallCnt     out  2      remaining stall cycles (debug)
// BEHAVIOUR
//  - Reset (Rst=0, async): state=RUN, StallCnt=0, stats=0.
//    While Rst=0: PCWrite=IFIDWrite=IDEXBubble=IFIDFlush=Redirect=0.
//  - Match m(x,d): x used && d!=0 && x==d, checked for rs and for rt.
//  - Hazard need N, computed only when Branch=1 (max of the following):
//    - EX load matching -> N=2.
//    - EX ALU write (ExRegWrite && !ExMemRead) matching -> N=1.
//    - MEM load matching -> N=1.
//    - Otherwise N=0.
//  - Outputs are combinational from state + inputs. Next state is registered.
//  - States:
//    - RUN, N>0, !ExtStall:
//      - PCWrite=0, IFIDWrite=0, IDEXBubble=1, Redirect=0.
//      - Next: StallCnt<=N-1. Go to STALL if N-1>0, else stay in RUN (re-evaluated next cycle).
//    - RUN, N=0:
//      - PCWrite=1, IFIDWrite=1, IDEXBubble=0.
//      - Redirect=Branch&Taken.
//      - IFIDFlush=Branch&Taken&(DELAY_SLOT==0).
//    - STALL:
//      - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
//      - StallCnt decrements. At 1->0 return to RUN.
//      - RUN re-evaluates the hazard; Branch/Taken are sampled only in RUN.
//  - ExtStall=1 has priority over everything:
//    - PCWrite=IFIDWrite=0; IDEXBubble=0; IFIDFlush=0; Redirect=0.
//    - State and StallCnt hold.
//  - j/jal: RsUsed=RtUsed=0, so never stalled; redirect in the same cycle.
//  - Reset asserted mid-STALL: returns to RUN immediately, count cleared.
//  - IFIDFlush and IFIDWrite may both be 1; flush wins in IF/ID.
// CONFIGURATION
//  - BRANCH_STATS_EN defined: adds outputs NumTaken[CNT_W], NumBranch[CNT_W], NumStall[CNT_W].
//    - Saturating counters, incremented on non-ExtStall cycles:
//      - NumBranch: RUN with Branch&N=0.
//      - NumTaken: Redirect=1.
//      - NumStall: IDEXBubble=1.
//    - Cleared by Rst.
//  - BRANCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - bne rs=8, no hazards, Taken=1 -> Redirect=1, IFIDFlush=1, PCWrite=1, same cycle.
//  - bne rs=8 with EX load ExDst=8 -> 2 cycles of PCWrite=0/IDEXBubble=1; cycle 3 Redirect per Taken.
//  - jr rs=31 with EX ALU write ExDst=31 -> 1 bubble cycle, then Redirect=1.
//  - Hazard on $0 (ExDst=0, load) -> no stall.
//  - Stall N=2 with ExtStall=1 on cycle 2 -> StallCnt holds at 1; bubble resumes after release; 2 bubble cycles total.
//  - Rst low mid-STALL -> outputs 0 at once; after release state=RUN, StallCnt=0.
//  - DELAY_SLOT=1, taken j -> Redirect=1, IFIDFlush=0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump hazard sequencer: stalls until branch operands can be
// forwarded, then redirects the PC and flushes IF/ID. Optional stats: BRANCH_STATS_EN.
module branch_hazard_ctrl #(
    parameter int DELAY_SLOT = 0
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Branch,
    input  logic       Taken,
    input  logic [4:0] IdRs,
    input  logic [4:0] IdRt,
    input  logic       RsUsed,
    input  logic       RtUsed,
    input  logic       ExRegWrite,
    input  logic       ExMemRead,
    input  logic [4:0] ExDst,
    input  logic       MemMemRead,
    input  logic [4:0] MemDst,
    input  logic       ExtStall,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXBubble,
    output logic       IFIDFlush,
    output logic       Redirect,
    output logic [1:0] StallCnt
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] NumTaken,
    output logic [CNT_W-1:0] NumBranch,
    output logic [CNT_W-1:0] NumStall
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic FLUSH_ON_TAKEN = (DELAY_SLOT == 0);

    state_t     state_p0, state_nxt;
    logic [1:0] cnt_p0, cnt_nxt;
    logic       ex_hit, mem_hit;
    logic [1:0] need;

    // $0 never creates a dependency: it is hardwired and never really written.
    function automatic logic reg_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (dst != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        ex_hit  = reg_match(RsUsed, IdRs, ExDst)  || reg_match(RtUsed, IdRt, ExDst);
        mem_hit = reg_match(RsUsed, IdRs, MemDst) || reg_match(RtUsed, IdRt, MemDst);
        need    = 2'd0;
        if (Branch) begin
            if (ExMemRead && ex_hit)
                need = 2'd2;
            else if ((ExRegWrite && !ExMemRead && ex_hit) || (MemMemRead && mem_hit))
                need = 2'd1;
        end
    end

    // ---- state register ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_p0 <= RUN;
            cnt_p0   <= 2'd0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // ---- next state and pipeline controls ----
    always_comb begin
        state_nxt  = state_p0;
        cnt_nxt    = cnt_p0;
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        Redirect   = 1'b0;
        if (Rst && !ExtStall) begin
            case (state_p0)
                RUN: begin
                    if (need != 2'd0) begin
                        IDEXBubble = 1'b1;
                        cnt_nxt    = need - 2'd1;
                        state_nxt  = (need > 2'd1) ? STALL : RUN;
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDWrite = 1'b1;
                        Redirect  = Branch && Taken;
                        IFIDFlush = Branch && Taken && FLUSH_ON_TAKEN;
                    end
                end
                STALL: begin
                    IDEXBubble = 1'b1;
                    cnt_nxt    = cnt_p0 - 2'd1;
                    if (cnt_p0 <= 2'd1) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign StallCnt = cnt_p0;

`ifdef BRANCH_STATS_EN
    logic branch_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign branch_ok = !ExtStall && (state_p0 == RUN) && Branch && (need == 2'd0);

    // ---- statistics ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            NumTaken  <= '0;
            NumBranch <= '0;
            NumStall  <= '0;
        end else begin
            if (branch_ok)
                NumBranch <= sat_inc(NumBranch);
            if (Redirect)
                NumTaken <= sat_inc(NumTaken);
            if (IDEXBubble)
                NumStall <= sat_inc(NumStall);
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Table-driven bench for branch_hazard_ctrl, plus hand sequences for
// delay-slot behaviour and reset asserted in the middle of a stall.
module tb_branch_hazard_ctrl;

    logic       Clk, Rst;
    logic       Branch, Taken, RsUsed, RtUsed, ExRegWrite, ExMemRead, MemMemRead, ExtStall;
    logic [4:0] IdRs, IdRt, ExDst, MemDst;
    logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Redirect;
    logic [1:0] StallCnt;
    logic       PCWrite1, IFIDWrite1, IDEXBubble1, IFIDFlush1, Redirect1;
    logic [1:0] StallCnt1;
`ifdef BRANCH_STATS_EN
    logic [31:0] NumTaken, NumBranch, NumStall;
    logic [31:0] NumTaken1, NumBranch1, NumStall1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    branch_hazard_ctrl #(.DELAY_SLOT(0)) dut (
        .Clk(Clk), .Rst(Rst), .Branch(Branch), .Taken(Taken),
        .IdRs(IdRs), .IdRt(IdRt), .RsUsed(RsUsed), .RtUsed(RtUsed),
        .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExDst(ExDst),
        .MemMemRead(MemMemRead), .MemDst(MemDst), .ExtStall(ExtStall),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .Redirect(Redirect), .StallCnt(StallCnt)
`ifdef BRANCH_STATS_EN
        , .NumTaken(NumTaken), .NumBranch(NumBranch), .NumStall(NumStall)
`endif
    );

    branch_hazard_ctrl #(.DELAY_SLOT(1)) dut_ds (
        .Clk(Clk), .Rst(Rst), .Branch(Branch), .Taken(Taken),
        .IdRs(IdRs), .IdRt(IdRt), .RsUsed(RsUsed), .RtUsed(RtUsed),
        .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExDst(ExDst),
        .MemMemRead(MemMemRead), .MemDst(MemDst), .ExtStall(ExtStall),
        .PCWrite(PCWrite1), .IFIDWrite(IFIDWrite1), .IDEXBubble(IDEXBubble1),
        .IFIDFlush(IFIDFlush1), .Redirect(Redirect1), .StallCnt(StallCnt1)
`ifdef BRANCH_STATS_EN
        , .NumTaken(NumTaken1), .NumBranch(NumBranch1), .NumStall(NumStall1)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       br, tk;
        logic [4:0] rs, rt;
        logic       rsu, rtu, exw, exr;
        logic [4:0] exd;
        logic       mr;
        logic [4:0] md;
        logic       xs;
        logic       pcw, ifw, bub, fl, red;
        logic [1:0] cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic br, input logic tk, input logic [4:0] rs, input logic [4:0] rt,
        input logic rsu, input logic rtu, input logic exw, input logic exr,
        input logic [4:0] exd, input logic mr, input logic [4:0] md, input logic xs,
        input logic pcw, input logic ifw, input logic bub, input logic fl,
        input logic red, input logic [1:0] cnt);
        vec_t v;
        v.br = br; v.tk = tk; v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu;
        v.exw = exw; v.exr = exr; v.exd = exd; v.mr = mr; v.md = md; v.xs = xs;
        v.pcw = pcw; v.ifw = ifw; v.bub = bub; v.fl = fl; v.red = red; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Branch = v.br; Taken = v.tk; IdRs = v.rs; IdRt = v.rt;
        RsUsed = v.rsu; RtUsed = v.rtu; ExRegWrite = v.exw; ExMemRead = v.exr;
        ExDst = v.exd; MemMemRead = v.mr; MemDst = v.md; ExtStall = v.xs;
    endtask

    task automatic check_outs(input string tag, input logic pcw, input logic ifw,
                              input logic bub, input logic fl, input logic red,
                              input logic [1:0] cnt);
        check({tag, ".PCWrite"},    32'(PCWrite),    32'(pcw));
        check({tag, ".IFIDWrite"},  32'(IFIDWrite),  32'(ifw));
        check({tag, ".IDEXBubble"}, 32'(IDEXBubble), 32'(bub));
        check({tag, ".IFIDFlush"},  32'(IFIDFlush),  32'(fl));
        check({tag, ".Redirect"},   32'(Redirect),   32'(red));
        check({tag, ".StallCnt"},   32'(StallCnt),   32'(cnt));
    endtask

    initial begin
        //          br tk rs rt rsu rtu exw exr exd mr md xs   pcw ifw bub fl red cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1, 0);
        vecs[2]  = mk(1, 0, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        vecs[5]  = mk(1, 1, 8, 9, 1, 1, 0, 0, 3, 0, 0, 0,   1, 1, 0, 1, 1, 0);
        vecs[6]  = mk(1, 1, 31, 0, 1, 0, 1, 0, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(1, 1, 31, 0, 1, 0, 1, 0, 5, 0, 31, 0, 1, 1, 0, 1, 1, 0);
        vecs[8]  = mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 4, 7, 1, 1, 0, 0, 0, 1, 7, 0,   0, 0, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 4, 7, 1, 0, 0, 0, 0, 1, 7, 0,   1, 1, 0, 1, 1, 0);
        vecs[11] = mk(0, 0, 8, 0, 1, 0, 1, 1, 8, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        vecs[13] = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        vecs[14] = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        vecs[15] = mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        vecs[16] = mk(1, 0, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[17] = mk(1, 1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        vecs[18] = mk(1, 1, 8, 0, 0, 0, 1, 1, 8, 0, 0, 0,   1, 1, 0, 1, 1, 0);
        vecs[19] = mk(1, 0, 5, 6, 1, 1, 1, 1, 6, 1, 5, 0,   0, 0, 1, 0, 0, 0);
        vecs[20] = mk(1, 0, 5, 6, 1, 1, 1, 1, 6, 1, 5, 0,   0, 0, 1, 0, 0, 1);
        vecs[21] = mk(1, 0, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
        vecs[22] = mk(1, 1, 8, 9, 1, 1, 0, 0, 8, 0, 0, 0,   1, 1, 0, 1, 1, 0);

        // Reset held with a taken branch presented: every control must stay low.
        Rst = 1'b0;
        drive(mk(1, 1, 8, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        check_outs("reset", 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        check("reset.NumBranch", NumBranch, 32'd0);
`endif
        @(posedge Clk);
        #1 Rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #2;
            check_outs($sformatf("vec%0d", i), vecs[i].pcw, vecs[i].ifw, vecs[i].bub,
                       vecs[i].fl, vecs[i].red, vecs[i].cnt);
            @(posedge Clk);
            #1;
        end

        // Taken j: delay-slot build redirects without flushing.
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("ds0.IFIDFlush", 32'(IFIDFlush),  32'd1);
        check("ds1.Redirect",  32'(Redirect1),  32'd1);
        check("ds1.IFIDFlush", 32'(IFIDFlush1), 32'd0);
        check("ds1.PCWrite",   32'(PCWrite1),   32'd1);
        @(posedge Clk);
        #1;

        // Enter STALL with an EX load hazard, then assert reset mid-stall.
        drive(mk(1, 1, 8, 9, 1, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        @(posedge Clk);
        #1;
        check("prestall.StallCnt", 32'(StallCnt), 32'd1);
        Rst = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0, 0, 0, 0);
        #1 Rst = 1'b1;
        Branch = 1'b0;
        #1;
        check_outs("postrst", 1, 1, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_outs("postrst2", 1, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
